// File: rtl/sech2_lut_loader.sv
// sech2_lut_loader: stream-loaded lookup table shared by independent per-channel lookup streams
module sech2_lut_loader #(
    parameter int DATA_WIDTH_DATA = 16,
    parameter int DATA_WIDTH_RSLT = 16,
    parameter int CHANNELS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_WIDTH_RSLT-1:0] s_axis_1_tdata,
    input  logic s_axis_1_tvalid,
    output logic s_axis_1_tready,
    input  logic s_axis_1_tlast,
    input  logic [CHANNELS*DATA_WIDTH_DATA-1:0] s_axis_0_tdata,
    input  logic [CHANNELS-1:0] s_axis_0_tvalid,
    output logic [CHANNELS-1:0] s_axis_0_tready,
    input  logic [CHANNELS-1:0] s_axis_0_tlast,
    output logic [CHANNELS*DATA_WIDTH_RSLT-1:0] m_axis_0_tdata,
    output logic [CHANNELS-1:0] m_axis_0_tvalid,
    output logic [CHANNELS-1:0] m_axis_0_tlast,
    input  logic [CHANNELS-1:0] m_axis_0_tready,
    output logic loaded,
    output logic err_short,
    output logic err_long
);
    localparam int DEPTH = 2**DATA_WIDTH_DATA;
    localparam logic [1:0] EMPTY = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, READY = 2'd3;
    logic [1:0] state;
    logic [DATA_WIDTH_DATA-1:0] wr_addr;
    logic [DATA_WIDTH_RSLT-1:0] lut [DEPTH];
    logic run, wr_en, at_end;
    // run holds the load port off while reset is asserted and releases it one edge later
    assign s_axis_1_tready = run;
    assign loaded = state == READY;
    assign wr_en = s_axis_1_tvalid && run && state != DRAIN;
    assign at_end = &wr_addr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            wr_addr <= '0;
            run <= 1'b0;
            err_short <= 1'b0;
            err_long <= 1'b0;
        end else begin
            run <= 1'b1;
            err_short <= wr_en && s_axis_1_tlast && !at_end;
            err_long <= wr_en && !s_axis_1_tlast && at_end;
            if (wr_en) begin
                wr_addr <= (s_axis_1_tlast || at_end) ? '0 : wr_addr + 1'b1;
                state <= s_axis_1_tlast ? (at_end ? READY : EMPTY) : (at_end ? DRAIN : LOAD);
            end else if (s_axis_1_tvalid && run && s_axis_1_tlast) begin
                state <= READY;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) lut[wr_addr] <= s_axis_1_tdata;
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic v, l, acc;
        logic [DATA_WIDTH_RSLT-1:0] d;
        assign s_axis_0_tready[c] = state == READY && !s_axis_1_tvalid && (!v || m_axis_0_tready[c]);
        assign acc = s_axis_0_tvalid[c] && s_axis_0_tready[c];
        assign m_axis_0_tvalid[c] = v;
        assign m_axis_0_tlast[c] = l;
        assign m_axis_0_tdata[c*DATA_WIDTH_RSLT +: DATA_WIDTH_RSLT] = d;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) v <= 1'b0;
            else v <= acc ? 1'b1 : (m_axis_0_tready[c] ? 1'b0 : v);
        end
        always_ff @(posedge clk) begin
            if (acc) begin
                d <= lut[s_axis_0_tdata[c*DATA_WIDTH_DATA +: DATA_WIDTH_DATA]];
                l <= s_axis_0_tlast[c];
            end
        end
    end
endmodule

// File: tb/tb_sech2_lut_loader.sv
// tb_sech2_lut_loader: scoreboard bench for the stream-loaded shared lookup table
module tb_sech2_lut_loader;
    localparam int DW = 4, RW = 16, CH = 2;
    logic clk = 1'b0, rst = 1'b0;
    logic [RW-1:0] s1_tdata = '0;
    logic s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [CH*DW-1:0] s0_tdata = '0;
    logic [CH-1:0] s0_tvalid = '0, s0_tlast = '0, s0_tready;
    logic [CH*RW-1:0] m_tdata;
    logic [CH-1:0] m_tvalid, m_tlast, m_tready = '1;
    logic loaded, err_short, err_long;
    logic [RW-1:0] model [16];
    logic [RW:0] sb [CH][$];
    int n_tests = 0, n_fail = 0;
    int n_out [CH] = '{0, 0};
    int es_cnt, el_cnt, es_at, el_at;

    sech2_lut_loader #(.DATA_WIDTH_DATA(DW), .DATA_WIDTH_RSLT(RW), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_1_tdata(s1_tdata), .s_axis_1_tvalid(s1_tvalid), .s_axis_1_tready(s1_tready), .s_axis_1_tlast(s1_tlast),
        .s_axis_0_tdata(s0_tdata), .s_axis_0_tvalid(s0_tvalid), .s_axis_0_tready(s0_tready), .s_axis_0_tlast(s0_tlast),
        .m_axis_0_tdata(m_tdata), .m_axis_0_tvalid(m_tvalid), .m_axis_0_tlast(m_tlast), .m_axis_0_tready(m_tready),
        .loaded(loaded), .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard runs mid-cycle: retire handshaken outputs, then enqueue newly accepted lookups
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) sb[c].delete();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (m_tvalid[c] && m_tready[c]) begin
                    chk($sformatf("sb_nonempty%0d", c), 32'(sb[c].size() > 0), 32'd1);
                    if (sb[c].size() > 0)
                        chk($sformatf("out%0d", c), 32'({m_tlast[c], m_tdata[c*RW +: RW]}), 32'(sb[c].pop_front()));
                    n_out[c]++;
                end
                if (s0_tvalid[c] && s0_tready[c])
                    sb[c].push_back({s0_tlast[c], model[s0_tdata[c*DW +: DW]]});
            end
        end
    end

    task automatic load(input int n, input logic [RW-1:0] base);
        es_cnt = 0; el_cnt = 0; es_at = 0; el_at = 0;
        for (int i = 0; i < n; i++) begin
            s1_tdata = base + RW'(i);
            s1_tlast = i == n - 1;
            s1_tvalid = 1'b1;
            if (i < 16) model[i] = s1_tdata;
            step();
            if (err_short) begin es_cnt++; es_at = i + 1; end
            if (err_long) begin el_cnt++; el_at = i + 1; end
        end
        s1_tvalid = 1'b0;
        s1_tlast = 1'b0;
        step();
        if (err_short) es_cnt++;
        if (err_long) el_cnt++;
    endtask

    task automatic lookup(input int c, input logic [DW-1:0] a, input logic l);
        s0_tdata[c*DW +: DW] = a;
        s0_tlast[c] = l;
        s0_tvalid[c] = 1'b1;
        #1;
        chk("lk_rdy", 32'(s0_tready[c]), 32'd1);
        step();
        s0_tvalid[c] = 1'b0;
        s0_tlast[c] = 1'b0;
        chk("lk_lat", 32'(m_tvalid[c]), 32'd1);
        step();
    endtask

    initial begin
        int a, base_cnt;
        logic acc;
        foreach (model[i]) model[i] = '0;
        repeat (2) step();
        chk("rst_s1_rdy", 32'(s1_tready), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'({err_short, err_long}), 32'd0);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s0_rdy", 32'(s0_tready), 32'd0);
        rst = 1'b1;
        step();
        chk("s1_rdy", 32'(s1_tready), 32'd1);
        s0_tdata = 8'h35;
        s0_tvalid = 2'b11;
        repeat (3) step();
        chk("empty_s0_rdy", 32'(s0_tready), 32'd0);
        chk("empty_mvalid", 32'(m_tvalid), 32'd0);
        chk("empty_loaded", 32'(loaded), 32'd0);
        s0_tvalid = '0;

        load(16, 16'h1000);
        chk("full_loaded", 32'(loaded), 32'd1);
        chk("full_errs", 32'(es_cnt + el_cnt), 32'd0);
        lookup(0, 4'd5, 1'b1);
        lookup(1, 4'hF, 1'b0);

        load(10, 16'h5000);
        chk("short_cnt", 32'(es_cnt), 32'd1);
        chk("short_at", 32'(es_at), 32'd10);
        chk("short_long", 32'(el_cnt), 32'd0);
        chk("short_loaded", 32'(loaded), 32'd0);
        load(16, 16'h2000);
        chk("reload_loaded", 32'(loaded), 32'd1);
        lookup(0, 4'd9, 1'b0);

        load(20, 16'h3000);
        chk("long_cnt", 32'(el_cnt), 32'd1);
        chk("long_at", 32'(el_at), 32'd16);
        chk("long_short", 32'(es_cnt), 32'd0);
        chk("long_loaded", 32'(loaded), 32'd1);
        lookup(0, 4'd0, 1'b0);
        lookup(1, 4'd15, 1'b1);

        m_tready[1] = 1'b0;
        lookup(1, 4'd3, 1'b0);
        base_cnt = n_out[0];
        a = 0;
        for (int k = 0; k < 300 && a < 16; k++) begin
            m_tready[0] = 1'($urandom_range(0, 1));
            s0_tdata[DW-1:0] = DW'(a);
            s0_tlast[0] = a == 15;
            s0_tvalid[0] = 1'b1;
            #1;
            acc = s0_tready[0];
            if (k == 3) chk("ch1_stall_rdy", 32'(s0_tready[1]), 32'd0);
            step();
            if (acc) a++;
        end
        chk("stream_done", 32'(a), 32'd16);
        s0_tvalid[0] = 1'b0;
        s0_tlast[0] = 1'b0;
        m_tready[0] = 1'b1;
        repeat (3) step();
        chk("ch0_count", 32'(n_out[0] - base_cnt), 32'd16);
        chk("ch1_hold", 32'(m_tvalid[1]), 32'd1);
        chk("ch1_data", 32'(m_tdata[2*RW-1:RW]), 32'(model[3]));
        m_tready[1] = 1'b1;
        step();
        chk("ch1_drained", 32'(m_tvalid[1]), 32'd0);

        for (int i = 0; i < 4; i++) begin
            s0_tdata[DW-1:0] = DW'(i);
            s0_tvalid[0] = 1'b1;
            step();
        end
        s1_tdata = 16'h6000;
        s1_tvalid = 1'b1;
        model[0] = s1_tdata;
        #1;
        chk("prio_s0_rdy", 32'(s0_tready[0]), 32'd0);
        step();
        chk("restart_loaded", 32'(loaded), 32'd0);
        s0_tvalid[0] = 1'b0;
        for (int i = 1; i < 6; i++) begin
            s1_tdata = 16'h6000 + RW'(i);
            model[i] = s1_tdata;
            step();
        end
        s1_tdata = 16'h6006;
        rst = 1'b0;
        #1;
        chk("mid_rst_s1_rdy", 32'(s1_tready), 32'd0);
        chk("mid_rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_s0_rdy", 32'(s0_tready), 32'd0);
        chk("mid_rst_loaded", 32'(loaded), 32'd0);
        s1_tvalid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        load(16, 16'h4000);
        chk("post_rst_loaded", 32'(loaded), 32'd1);
        chk("post_rst_errs", 32'(es_cnt + el_cnt), 32'd0);
        lookup(0, 4'd0, 1'b0);
        lookup(1, 4'd6, 1'b1);
        lookup(0, 4'd15, 1'b0);

        repeat (3) step();
        chk("sb0_empty", 32'(sb[0].size()), 32'd0);
        chk("sb1_empty", 32'(sb[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
